// File: rtl/dmi_regbus_bridge_pkg.sv
// Shared types for the DMI to register-bus bridge.
// Holds DMI op/resp encodings, bridge FSM states and default widths.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    NOP   = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    SUCCESS = 2'd0,
    FAILED  = 2'd2,
    BUSY    = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/dmi_regbus_bridge_if.sv
// DMI request/response channels plus the register-bus channel.
// slave: bridge view; master: DTM / register-file view.
interface dmi_regbus_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);

  logic              debug_req_valid;
  logic              debug_req_ready;
  logic [ADDR_W-1:0] debug_req_bits_addr;
  logic [1:0]        debug_req_bits_op;
  logic [DATA_W-1:0] debug_req_bits_data;

  logic              debug_resp_valid;
  logic              debug_resp_ready;
  logic [1:0]        debug_resp_bits_resp;
  logic [DATA_W-1:0] debug_resp_bits_data;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic              bus_req_write;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [DATA_W-1:0] bus_req_wdata;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_rdata;
  logic              bus_resp_err;

  modport slave (
    input  debug_req_valid,
    output debug_req_ready,
    input  debug_req_bits_addr,
    input  debug_req_bits_op,
    input  debug_req_bits_data,
    output debug_resp_valid,
    input  debug_resp_ready,
    output debug_resp_bits_resp,
    output debug_resp_bits_data,
    output bus_req_valid,
    input  bus_req_ready,
    output bus_req_write,
    output bus_req_addr,
    output bus_req_wdata,
    input  bus_resp_valid,
    input  bus_resp_rdata,
    input  bus_resp_err
  );

  modport master (
    output debug_req_valid,
    input  debug_req_ready,
    output debug_req_bits_addr,
    output debug_req_bits_op,
    output debug_req_bits_data,
    input  debug_resp_valid,
    output debug_resp_ready,
    input  debug_resp_bits_resp,
    input  debug_resp_bits_data,
    input  bus_req_valid,
    output bus_req_ready,
    input  bus_req_write,
    input  bus_req_addr,
    input  bus_req_wdata,
    output bus_resp_valid,
    output bus_resp_rdata,
    output bus_resp_err
  );

endinterface

// File: rtl/dmi_regbus_bridge.sv
// Executes one DMI request at a time as a register-bus transaction.
// Ports: clk, reset_n (sync, active-low), dmi (slave modport), busy.
module dmi_regbus_bridge
  import dmi_pkg::*;
#(
  parameter int ADDR_W  = DMI_ADDR_W,
  parameter int DATA_W  = DMI_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dmi_regbus_bridge_if.slave   dmi,
  output logic                 busy
);

  localparam int CNT_W =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL =
    CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bridge_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q;
  dmi_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  dmi_resp_e         resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cap;
  logic              timed_out;
  dmi_resp_e         bus_resp;
  logic [DATA_W-1:0] bus_data;

  // Ready is a flop so it stays low while reset is held.
  assign timed_out = (TIMEOUT != 0) &&
                     (cnt_q == TO_VAL);

  assign bus_resp = dmi.bus_resp_err ?
                    FAILED : SUCCESS;
  assign bus_data = (op_q == READ) ?
                    dmi.bus_resp_rdata : '0;

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    rdata_d = rdata_q;
    cap     = 1'b0;
    cnt_d   = cnt_q;
    if ((state_q == ISSUE || state_q == WAIT) &&
        cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (rdy_q && dmi.debug_req_valid) begin
          cap   = 1'b1;
          cnt_d = '0;
          unique case (dmi_op_e'(dmi.debug_req_bits_op))
            NOP: begin
              state_d = RESP;
              resp_d  = SUCCESS;
              rdata_d = '0;
            end
            RSVD: begin
              state_d = RESP;
              resp_d  = FAILED;
              rdata_d = '0;
            end
            READ, WRITE: begin
              state_d = ISSUE;
            end
          endcase
        end
      end
      ISSUE: begin
        // Response in the acceptance cycle beats timeout.
        if (dmi.bus_req_ready &&
            dmi.bus_resp_valid) begin
          state_d = RESP;
          resp_d  = bus_resp;
          rdata_d = bus_data;
        end else if (timed_out) begin
          state_d = RESP;
          resp_d  = FAILED;
          rdata_d = '0;
        end else if (dmi.bus_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmi.bus_resp_valid) begin
          state_d = RESP;
          resp_d  = bus_resp;
          rdata_d = bus_data;
        end else if (timed_out) begin
          state_d = RESP;
          resp_d  = FAILED;
          rdata_d = '0;
        end
      end
      RESP: begin
        if (dmi.debug_resp_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      op_q    <= NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= SUCCESS;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == IDLE);
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      if (cap) begin
        op_q    <= dmi_op_e'(dmi.debug_req_bits_op);
        addr_q  <= dmi.debug_req_bits_addr;
        wdata_q <= dmi.debug_req_bits_data;
      end
    end
  end

  assign dmi.debug_req_ready      = rdy_q;
  assign dmi.debug_resp_valid     = (state_q == RESP);
  assign dmi.debug_resp_bits_resp = resp_q;
  assign dmi.debug_resp_bits_data = rdata_q;
  assign dmi.bus_req_valid        = (state_q == ISSUE);
  assign dmi.bus_req_write        = (op_q == WRITE);
  assign dmi.bus_req_addr         = addr_q;
  assign dmi.bus_req_wdata        = wdata_q;
  assign busy                     = (state_q != IDLE);

endmodule

// File: tb/tb_dmi_regbus_bridge.sv
// Directed bench for dmi_regbus_bridge with TIMEOUT=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_dmi_regbus_bridge;

  logic clk;
  logic reset_n;
  logic busy;
  int   total;
  int   bad;
  int   n;

  dmi_regbus_bridge_if #(.ADDR_W(7), .DATA_W(32)) dmi ();

  dmi_regbus_bridge #(
    .ADDR_W (7),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .dmi    (dmi),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_rdy(input string tag);
    int k;
    k = 0;
    while (!dmi.debug_req_ready && k < 20) begin
      step();
      k++;
    end
    chk(tag, 32'(dmi.debug_req_ready), 32'd1);
  endtask

  task automatic send_req(input logic [1:0]  op,
                          input logic [6:0]  addr,
                          input logic [31:0] data);
    wait_rdy("req_rdy");
    dmi.debug_req_valid     = 1'b1;
    dmi.debug_req_bits_op   = op;
    dmi.debug_req_bits_addr = addr;
    dmi.debug_req_bits_data = data;
    step();
    dmi.debug_req_valid     = 1'b0;
  endtask

  task automatic bus_pulse(input logic [31:0] rdata,
                           input logic        err);
    dmi.bus_resp_valid = 1'b1;
    dmi.bus_resp_rdata = rdata;
    dmi.bus_resp_err   = err;
    step();
    dmi.bus_resp_valid = 1'b0;
    dmi.bus_resp_rdata = '0;
    dmi.bus_resp_err   = 1'b0;
  endtask

  task automatic finish_resp(input string tag,
                             input logic [1:0]  resp,
                             input logic [31:0] data);
    int k;
    k = 0;
    while (!dmi.debug_resp_valid && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_vld"},
        32'(dmi.debug_resp_valid), 32'd1);
    chk({tag, "_resp"},
        32'(dmi.debug_resp_bits_resp), 32'(resp));
    chk({tag, "_data"},
        dmi.debug_resp_bits_data, data);
    dmi.debug_resp_ready = 1'b1;
    step();
    dmi.debug_resp_ready = 1'b0;
    chk({tag, "_drop"},
        32'(dmi.debug_resp_valid), 32'd0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_rdy"},
        32'(dmi.debug_req_ready), 32'd0);
    chk({tag, "_rv"},
        32'(dmi.debug_resp_valid), 32'd0);
    chk({tag, "_bv"},
        32'(dmi.bus_req_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd"},
        dmi.debug_resp_bits_data, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n                 = 1'b0;
    dmi.debug_req_valid     = 1'b0;
    dmi.debug_req_bits_addr = '0;
    dmi.debug_req_bits_op   = '0;
    dmi.debug_req_bits_data = '0;
    dmi.debug_resp_ready    = 1'b0;
    dmi.bus_req_ready       = 1'b0;
    dmi.bus_resp_valid      = 1'b0;
    dmi.bus_resp_rdata      = '0;
    dmi.bus_resp_err        = 1'b0;
    step();
    step();
    chk_idle_outs("rst");
    reset_n = 1'b1;

    // Read, bus accepts at once, response one cycle later.
    dmi.bus_req_ready = 1'b1;
    send_req(2'd1, 7'h11, 32'h0);
    chk("rd_bv", 32'(dmi.bus_req_valid), 32'd1);
    chk("rd_bw", 32'(dmi.bus_req_write), 32'd0);
    chk("rd_ba", 32'(dmi.bus_req_addr), 32'h11);
    chk("rd_rdy", 32'(dmi.debug_req_ready), 32'd0);
    step();
    chk("rd_wbv", 32'(dmi.bus_req_valid), 32'd0);
    chk("rd_wrdy", 32'(dmi.debug_req_ready), 32'd0);
    bus_pulse(32'hDEADBEEF, 1'b0);
    chk("rd_rrdy", 32'(dmi.debug_req_ready), 32'd0);
    finish_resp("rd", 2'd0, 32'hDEADBEEF);

    // Write that the slave rejects.
    send_req(2'd2, 7'h10, 32'h80000001);
    chk("wr_bv", 32'(dmi.bus_req_valid), 32'd1);
    chk("wr_bw", 32'(dmi.bus_req_write), 32'd1);
    chk("wr_ba", 32'(dmi.bus_req_addr), 32'h10);
    chk("wr_wd", dmi.bus_req_wdata, 32'h80000001);
    step();
    bus_pulse(32'h12345678, 1'b1);
    finish_resp("wr", 2'd2, 32'h0);

    // Nop: response visible right after accept.
    send_req(2'd0, 7'h01, 32'hFFFF);
    chk("nop_rv", 32'(dmi.debug_resp_valid), 32'd1);
    chk("nop_bv", 32'(dmi.bus_req_valid), 32'd0);
    finish_resp("nop", 2'd0, 32'h0);

    // Reserved op fails without touching the bus.
    send_req(2'd3, 7'h02, 32'h5);
    chk("rsv_rv", 32'(dmi.debug_resp_valid), 32'd1);
    chk("rsv_bv", 32'(dmi.bus_req_valid), 32'd0);
    finish_resp("rsv", 2'd2, 32'h0);

    // Timeout while the bus never accepts.
    dmi.bus_req_ready = 1'b0;
    send_req(2'd1, 7'h05, 32'h0);
    n = 0;
    while (dmi.bus_req_valid && n < 30) begin
      n++;
      step();
    end
    chk("to0_len", 32'(n), 32'd9);
    chk("to0_bv", 32'(dmi.bus_req_valid), 32'd0);
    finish_resp("to0", 2'd2, 32'h0);

    // Timeout after accept with no response; late pulse ignored.
    dmi.bus_req_ready = 1'b1;
    send_req(2'd1, 7'h06, 32'h0);
    n = 0;
    while (!dmi.debug_resp_valid && n < 30) begin
      n++;
      step();
    end
    chk("to1_len", 32'(n), 32'd9);
    chk("to1_bv", 32'(dmi.bus_req_valid), 32'd0);
    step();
    step();
    bus_pulse(32'hCAFEF00D, 1'b0);
    chk("to1_late_rv",
        32'(dmi.debug_resp_valid), 32'd1);
    finish_resp("to1", 2'd2, 32'h0);

    // Response backpressure with a pending request.
    send_req(2'd1, 7'h22, 32'h0);
    step();
    bus_pulse(32'h0A0B0C0D, 1'b0);
    dmi.debug_req_valid     = 1'b1;
    dmi.debug_req_bits_op   = 2'd0;
    dmi.debug_req_bits_addr = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", 32'(dmi.debug_resp_valid), 32'd1);
      chk("bp_data",
          dmi.debug_resp_bits_data, 32'h0A0B0C0D);
      chk("bp_rdy",
          32'(dmi.debug_req_ready), 32'd0);
      step();
    end
    dmi.debug_resp_ready = 1'b1;
    step();
    dmi.debug_resp_ready = 1'b0;
    chk("bp_idle_rv", 32'(dmi.debug_resp_valid), 32'd0);
    chk("bp_idle_rdy", 32'(dmi.debug_req_ready), 32'd1);
    step();
    dmi.debug_req_valid = 1'b0;
    chk("bp_acc_rv", 32'(dmi.debug_resp_valid), 32'd1);
    finish_resp("bp_nop", 2'd0, 32'h0);

    // Reset while waiting for the bus response.
    send_req(2'd1, 7'h33, 32'h0);
    step();
    chk("mr_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    step();
    chk_idle_outs("mr");
    reset_n = 1'b1;
    bus_pulse(32'h11111111, 1'b0);
    chk("mr_stale_rv", 32'(dmi.debug_resp_valid), 32'd0);
    chk("mr_stale_busy", 32'(busy), 32'd0);
    send_req(2'd1, 7'h34, 32'h0);
    chk("mr_ba", 32'(dmi.bus_req_addr), 32'h34);
    step();
    bus_pulse(32'h55AA55AA, 1'b0);
    finish_resp("mr_rd", 2'd0, 32'h55AA55AA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
